// File: rtl/aibcr3_rambit_chain.sv
`default_nettype none
// ============================================================================
// Module   : aibcr3_rambit_chain
// Purpose  : Scan-loaded configuration-bit bank. A serial shift register
//            collects a frame of NBITS data bits plus an optional even-parity
//            bit. An update pulse copies the data bits into a shadow register
//            only when the frame length and parity are correct. Only the
//            shadow register drives the configuration outputs.
// Ports    : clk       - scan/config clock
//            rstb      - asynchronous active-low reset
//            shift_en  - shift one bit per cycle while high
//            scan_in   - serial input, enters at the MSB end of the frame
//            scan_out  - serial output (shift register bit 0), for chaining
//            update    - request to transfer the frame into the shadow
//            sig_out   - configuration bits (shadow register)
//            upd_ok    - one-cycle pulse after an accepted update
//            upd_err   - sticky flag, set by any rejected update
//            shift_cnt - saturating count of bits shifted since last update
// Revision : 1.0 - initial release
// ============================================================================
module aibcr3_rambit_chain #(
  parameter int               NBITS   = 16,
  parameter int               PAR_EN  = 1,
  parameter logic [NBITS-1:0] RST_VAL = '0,
  localparam int              L       = NBITS + PAR_EN,
  localparam int              CW      = $clog2(NBITS + PAR_EN + 1) + 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             shift_en,
  input  logic             scan_in,
  output logic             scan_out,
  input  logic             update,
  output logic [NBITS-1:0] sig_out,
  output logic             upd_ok,
  output logic             upd_err,
  output logic [CW-1:0]    shift_cnt
);

  localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] C_FRAME   = CW'(L);

  logic [L-1:0]     r_sr;
  logic [L-1:0]     w_sr_next;
  logic [NBITS-1:0] r_shadow;
  logic             r_upd_ok;
  logic             r_upd_err;
  logic [CW-1:0]    r_cnt;

  logic             w_len_ok;
  logic             w_par_ok;
  logic             w_accept;
  logic             w_reject;

  // A one-bit frame has no upper part to shift down, so it just reloads.
  generate
    if (L == 1) begin : g_len1
      assign w_sr_next = scan_in;
    end else begin : g_lenn
      assign w_sr_next = {scan_in, r_sr[L-1:1]};
    end
  endgenerate

  // Parity covers the whole frame including the parity bit in r_sr[0].
  assign w_len_ok = (r_cnt == C_FRAME);
  assign w_par_ok = (PAR_EN == 0) ? 1'b1 : ~(^r_sr);

  // An update coinciding with a shift is always refused: the frame is moving.
  assign w_accept = update & ~shift_en & w_len_ok & w_par_ok;
  assign w_reject = update & ~w_accept;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sr      <= '0;
      r_shadow  <= RST_VAL;
      r_upd_ok  <= 1'b0;
      r_upd_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_upd_ok <= w_accept;

      if (shift_en) begin
        r_sr <= w_sr_next;
      end

      if (w_accept) begin
        r_shadow <= r_sr[L-1:PAR_EN];
      end

      if (w_reject) begin
        r_upd_err <= 1'b1;
      end

      // Shifting has priority over the count clear of an update.
      if (shift_en) begin
        if (r_cnt != C_CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (update) begin
        r_cnt <= '0;
      end
    end
  end

  assign scan_out  = r_sr[0];
  assign sig_out   = r_shadow;
  assign upd_ok    = r_upd_ok;
  assign upd_err   = r_upd_err;
  assign shift_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aibcr3_rambit_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_aibcr3_rambit_chain
// Purpose  : Directed self-checking bench. One 16-bit parity-protected
//            instance plus two 8-bit instances daisy-chained without parity.
//            Update results are predicted into a queue when the update is
//            driven and popped after the clock edge that produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aibcr3_rambit_chain;

  localparam logic [15:0] C_RST = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;

  // main instance
  logic        shift_en = 1'b0;
  logic        scan_in = 1'b0;
  logic        update = 1'b0;
  logic        scan_out;
  logic [15:0] sig_out;
  logic        upd_ok;
  logic        upd_err;
  logic [5:0]  shift_cnt;

  // chained instances
  logic        c_shift = 1'b0;
  logic        c_in = 1'b0;
  logic        c_upd = 1'b0;
  logic        a_so, b_so;
  logic [7:0]  a_sig, b_sig;
  logic        a_ok, b_ok, a_err, b_err;
  logic [4:0]  a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;

  // bench model of the main instance
  logic [16:0] m_sr  = '0;
  logic [15:0] m_sig = C_RST;
  logic        m_err = 1'b0;
  int          m_cnt = 0;

  typedef struct {
    string       tag;
    logic [15:0] sig;
    logic        ok;
    logic        err;
    logic [5:0]  cnt;
  } exp_t;

  exp_t sb[$];

  aibcr3_rambit_chain #(.NBITS(16), .PAR_EN(1), .RST_VAL(C_RST)) dut (
    .clk(clk), .rstb(rstb), .shift_en(shift_en), .scan_in(scan_in),
    .scan_out(scan_out), .update(update), .sig_out(sig_out),
    .upd_ok(upd_ok), .upd_err(upd_err), .shift_cnt(shift_cnt)
  );

  aibcr3_rambit_chain #(.NBITS(8), .PAR_EN(0), .RST_VAL(8'h00)) dut_a (
    .clk(clk), .rstb(rstb), .shift_en(c_shift), .scan_in(c_in),
    .scan_out(a_so), .update(c_upd), .sig_out(a_sig),
    .upd_ok(a_ok), .upd_err(a_err), .shift_cnt(a_cnt)
  );

  aibcr3_rambit_chain #(.NBITS(8), .PAR_EN(0), .RST_VAL(8'h00)) dut_b (
    .clk(clk), .rstb(rstb), .shift_en(c_shift), .scan_in(a_so),
    .scan_out(b_so), .update(c_upd), .sig_out(b_sig),
    .upd_ok(b_ok), .upd_err(b_err), .shift_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_main(input logic b);
    shift_en = 1'b1;
    scan_in  = b;
    m_sr     = {b, m_sr[16:1]};
    m_cnt    = (m_cnt < 63) ? m_cnt + 1 : 63;
    tick();
    shift_en = 1'b0;
  endtask

  // parity bit first, then data LSB-first, so parity lands in sr[0]
  task automatic shift_frame(input logic [15:0] data, input logic p);
    shift_main(p);
    for (int i = 0; i < 16; i++) shift_main(data[i]);
  endtask

  task automatic do_update(input string tag, input logic with_shift, input logic b);
    exp_t e;
    exp_t got;
    logic acc;
    if (with_shift) begin
      m_sr  = {b, m_sr[16:1]};
      m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
      acc   = 1'b0;
    end else begin
      acc   = (m_cnt == 17) && ((^m_sr) == 1'b0);
      m_cnt = 0;
    end
    if (acc) m_sig = m_sr[16:1];
    else     m_err = 1'b1;
    e.tag = tag; e.sig = m_sig; e.ok = acc; e.err = m_err; e.cnt = 6'(m_cnt);
    sb.push_back(e);

    update   = 1'b1;
    shift_en = with_shift;
    scan_in  = b;
    tick();
    update   = 1'b0;
    shift_en = 1'b0;

    got = sb.pop_front();
    chk({got.tag, "_sig"}, 32'(sig_out),   32'(got.sig));
    chk({got.tag, "_ok"},  32'(upd_ok),    32'(got.ok));
    chk({got.tag, "_err"}, 32'(upd_err),   32'(got.err));
    chk({got.tag, "_cnt"}, 32'(shift_cnt), 32'(got.cnt));
    tick();
    chk({got.tag, "_ok_gone"}, 32'(upd_ok), 32'd0);
  endtask

  task automatic shift_chain(input logic b);
    c_shift = 1'b1;
    c_in    = b;
    tick();
    c_shift = 1'b0;
  endtask

  initial begin
    logic [15:0] stream;
    logic [7:0]  byte2;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    tick();
    chk("rst_sig",  32'(sig_out),   32'(C_RST));
    chk("rst_err",  32'(upd_err),   32'd0);
    chk("rst_ok",   32'(upd_ok),    32'd0);
    chk("rst_cnt",  32'(shift_cnt), 32'd0);
    chk("rst_so",   32'(scan_out),  32'd0);
    chk("rst_asig", 32'(a_sig),     32'd0);

    // ---------------- good frame ----------------
    shift_frame(16'h1234, ^16'h1234);
    chk("good1_cnt", 32'(shift_cnt), 32'd17);
    chk("good1_so",  32'(scan_out),  32'(m_sr[0]));
    do_update("good1", 1'b0, 1'b0);

    // ---------------- parity error ----------------
    shift_frame(16'hBEEF, ~(^16'hBEEF));
    do_update("badpar", 1'b0, 1'b0);

    // ---------------- good frame after error: err stays sticky ----------------
    shift_frame(16'h5A5A, ^16'h5A5A);
    do_update("good2", 1'b0, 1'b0);

    // ---------------- short frame ----------------
    for (int i = 0; i < 16; i++) shift_main(i[0]);
    chk("short_cnt", 32'(shift_cnt), 32'd16);
    do_update("short", 1'b0, 1'b0);

    // ---------------- back-to-back update ----------------
    do_update("b2b", 1'b0, 1'b0);

    // ---------------- update together with shift ----------------
    shift_frame(16'h0F0F, ^16'h0F0F);
    do_update("collide", 1'b1, 1'b1);
    do_update("clear", 1'b0, 1'b0);

    // ---------------- count and saturation ----------------
    for (int i = 0; i < 40; i++) shift_main(1'($urandom_range(0, 1)));
    chk("cnt40",    32'(shift_cnt), 32'd40);
    chk("cnt40_so", 32'(scan_out),  32'(m_sr[0]));
    for (int i = 0; i < 30; i++) shift_main(1'b1);
    chk("cnt_sat",  32'(shift_cnt), 32'd63);
    do_update("sat_upd", 1'b0, 1'b0);

    // ---------------- daisy chain ----------------
    stream = 16'hC35A;
    for (int k = 1; k <= 16; k++) begin
      shift_chain(stream[k-1]);
      chk($sformatf("chain_aso_%0d", k), 32'(a_so), (k >= 8) ? 32'(stream[k-8]) : 32'd0);
    end
    chk("chain_bso", 32'(b_so),  32'(stream[0]));
    chk("chain_cnt", 32'(a_cnt), 32'd16);
    // 16 shifts is not an 8-bit frame: both refuse and clear their counts
    c_upd = 1'b1;
    tick();
    c_upd = 1'b0;
    chk("chain_rej_aerr", 32'(a_err), 32'd1);
    chk("chain_rej_berr", 32'(b_err), 32'd1);
    chk("chain_rej_asig", 32'(a_sig), 32'd0);
    chk("chain_rej_bcnt", 32'(b_cnt), 32'd0);
    // 8 more bits: A takes the new byte, B takes what A was holding
    byte2 = 8'h96;
    for (int i = 0; i < 8; i++) shift_chain(byte2[i]);
    c_upd = 1'b1;
    tick();
    c_upd = 1'b0;
    chk("chain_asig", 32'(a_sig), 32'(byte2));
    chk("chain_bsig", 32'(b_sig), 32'(stream[15:8]));
    chk("chain_aok",  32'(a_ok),  32'd1);
    chk("chain_bok",  32'(b_ok),  32'd1);

    // ---------------- asynchronous reset mid-shift ----------------
    shift_en = 1'b1;
    c_shift  = 1'b1;
    scan_in  = 1'b1;
    c_in     = 1'b1;
    repeat (3) @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("arst_sig",  32'(sig_out),   32'(C_RST));
    chk("arst_err",  32'(upd_err),   32'd0);
    chk("arst_cnt",  32'(shift_cnt), 32'd0);
    chk("arst_so",   32'(scan_out),  32'd0);
    chk("arst_asig", 32'(a_sig),     32'd0);
    chk("arst_bsig", 32'(b_sig),     32'd0);
    chk("arst_aerr", 32'(a_err),     32'd0);
    chk("arst_aso",  32'(a_so),      32'd0);
    shift_en = 1'b0;
    c_shift  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    tick();
    chk("post_rst_sig", 32'(sig_out), 32'(C_RST));
    chk("post_rst_cnt", 32'(shift_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute bound so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
